web1_wake_event_core: RTL and testbench

// - Hardware (sp) side of the web1 wake-event-block register set: the logic behind the sp modports.
// - Conditions 64 async wake inputs (sync, invert, enable) and edge-detects four event sources.
// - Sets the sticky event bits through the *_d/*_enb fields.
// - Runs the low-power entry/exit handshake with the power controller; sits between the regblock and the PMU.

---
 rtl/web1_wake_event_core_if.sv | 32 +++
 rtl/web1_wake_event_core.sv | 171 +++++++++++++++++
 tb/tb_web1_wake_event_core.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/web1_wake_event_core_if.sv
// Register-block views used by the web1 wake-event core: control edge
// selects, sticky event fields, and the two 32-bit enable/invert banks.
interface web1_control_if;
  logic [1:0] activate_low_pwr_edge_q;
  logic [1:0] event_suppress_edge_q;
  logic [1:0] wake_now_edge_q;
  logic [1:0] epu_enable_edge_q;
  modport sp (input activate_low_pwr_edge_q, event_suppress_edge_q,
              wake_now_edge_q, epu_enable_edge_q);
endinterface

interface web1_event_if;
  logic activate_low_pwr_q, activate_low_pwr_d, activate_low_pwr_enb;
  logic event_suppress_q, event_suppress_d, event_suppress_enb;
  logic wake_now_q, wake_now_d, wake_now_enb;
  logic epu_enable_q, epu_enable_d, epu_enable_enb;
  modport sp (input  activate_low_pwr_q, event_suppress_q, wake_now_q, epu_enable_q,
              output activate_low_pwr_d, activate_low_pwr_enb,
                     event_suppress_d, event_suppress_enb,
                     wake_now_d, wake_now_enb,
                     epu_enable_d, epu_enable_enb);
endinterface

interface web1_wake_enable_if;
  logic [31:0] enable_q;
  modport sp (input enable_q);
endinterface

interface web1_input_invert_if;
  logic [31:0] invert_q;
  modport sp (input invert_q);
endinterface

// File: rtl/web1_wake_event_core.sv
// Hardware side of the web1 wake-event block: wake input conditioning,
// event edge detection into the sticky fields, and the PMU sleep handshake.
module web1_wake_event_core #(
  parameter int unsigned NUM_WAKE    = 64,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  web1_control_if.sp          control_if,
  web1_event_if.sp            event_if,
  web1_wake_enable_if.sp      wake_en0_if,
  web1_wake_enable_if.sp      wake_en1_if,
  web1_input_invert_if.sp     invert0_if,
  web1_input_invert_if.sp     invert1_if,
  input  logic [NUM_WAKE-1:0] wake_in,
  input  logic                lp_req_i,
  input  logic                suppress_i,
  input  logic                epu_en_i,
  input  logic                pwr_ack_i,
  output logic                pwr_req_o,
  output logic                wake_irq_o,
  output logic                timeout_o,
  output logic [5:0]          wake_id_o
);

  typedef enum logic [1:0] {S_RUN, S_ENTER, S_SLEEP, S_EXIT} state_t;

  logic [NUM_WAKE-1:0] sync_q [SYNC_STAGES];
  logic [NUM_WAKE-1:0] wake_m;
  logic                wake_any;
  logic [5:0]          low_id;
  logic                low_found;

  logic [3:0][1:0]     edge_cfg;
  logic [3:0]          src_cur, prev_q, detect, enb_q;
  logic                armed_q;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                irq_d, to_d;
  logic [5:0]          id_d;
  logic                wake_ok;
  logic                unused_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= wake_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wake_m   = (sync_q[SYNC_STAGES-1] ^ {invert1_if.invert_q, invert0_if.invert_q})
                  & {wake_en1_if.enable_q, wake_en0_if.enable_q};
  assign wake_any = |wake_m;

  always_comb begin
    low_id    = '0;
    low_found = 1'b0;
    for (int unsigned i = 0; i < NUM_WAKE; i++) begin
      if (wake_m[i] && !low_found) begin
        low_id    = 6'(i);
        low_found = 1'b1;
      end
    end
  end

  // Source index: 0 activate_low_pwr, 1 event_suppress, 2 wake_now, 3 epu_enable
  assign edge_cfg = {control_if.epu_enable_edge_q, control_if.wake_now_edge_q,
                     control_if.event_suppress_edge_q, control_if.activate_low_pwr_edge_q};
  assign src_cur  = {epu_en_i, wake_any, suppress_i, lp_req_i};

  // armed_q masks the first post-reset cycle, where prev_q only loads src_cur
  always_comb begin
    detect = '0;
    if (armed_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        detect[i] = (edge_cfg[i][0] &  src_cur[i] & ~prev_q[i])
                  | (edge_cfg[i][1] & ~src_cur[i] &  prev_q[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q  <= '0;
      armed_q <= 1'b0;
      enb_q   <= '0;
    end else begin
      prev_q  <= src_cur;
      armed_q <= 1'b1;
      enb_q   <= detect;
    end
  end

  assign event_if.activate_low_pwr_enb = enb_q[0];
  assign event_if.activate_low_pwr_d   = enb_q[0];
  assign event_if.event_suppress_enb   = enb_q[1];
  assign event_if.event_suppress_d     = enb_q[1];
  assign event_if.wake_now_enb         = enb_q[2];
  assign event_if.wake_now_d           = enb_q[2];
  assign event_if.epu_enable_enb       = enb_q[3];
  assign event_if.epu_enable_d         = enb_q[3];

  assign unused_q = ^{event_if.activate_low_pwr_q, event_if.event_suppress_q,
                      event_if.wake_now_q, event_if.epu_enable_q};

  assign wake_ok = wake_any & ~suppress_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    irq_d   = 1'b0;
    to_d    = 1'b0;
    id_d    = wake_id_o;
    unique case (state_q)
      S_RUN: begin
        if (detect[0] && epu_en_i) begin
          state_d = S_ENTER;
          cnt_d   = '0;
        end
      end
      S_ENTER: begin
        cnt_d = cnt_q + 8'd1;
        // abort on a live wake has priority over the acknowledge
        if (wake_ok) begin
          state_d = S_RUN;
        end else if (pwr_ack_i) begin
          state_d = S_SLEEP;
        end else if (cnt_q == 8'(ACK_TIMEOUT)) begin
          state_d = S_RUN;
          to_d    = 1'b1;
        end
      end
      S_SLEEP: begin
        if (wake_ok) begin
          state_d = S_EXIT;
          id_d    = low_id;
        end
      end
      S_EXIT: begin
        if (!pwr_ack_i) begin
          state_d = S_RUN;
          irq_d   = 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      cnt_q      <= '0;
      wake_irq_o <= 1'b0;
      timeout_o  <= 1'b0;
      wake_id_o  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wake_irq_o <= irq_d;
      timeout_o  <= to_d;
      wake_id_o  <= id_d;
    end
  end

  assign pwr_req_o = (state_q == S_ENTER) || (state_q == S_SLEEP);

endmodule

// File: tb/tb_web1_wake_event_core.sv
// Bench for web1_wake_event_core: hand-derived vector table, directed
// sleep/suppress/timeout/abort sequences, and random traffic against a model.
module tb_web1_wake_event_core;
  localparam int unsigned SYNC = 2;
  localparam int unsigned TMO  = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] wake_in = '0;
  logic        lp = 1'b0, sup = 1'b0, epu = 1'b0, ack = 1'b0;
  logic        req, irq, tmo;
  logic [5:0]  wid;

  web1_control_if      ctl ();
  web1_event_if        evt ();
  web1_wake_enable_if  en0 ();
  web1_wake_enable_if  en1 ();
  web1_input_invert_if inv0 ();
  web1_input_invert_if inv1 ();

  web1_wake_event_core #(.NUM_WAKE(64), .SYNC_STAGES(SYNC), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .control_if(ctl), .event_if(evt),
    .wake_en0_if(en0), .wake_en1_if(en1),
    .invert0_if(inv0), .invert1_if(inv1),
    .wake_in(wake_in), .lp_req_i(lp), .suppress_i(sup), .epu_en_i(epu),
    .pwr_ack_i(ack), .pwr_req_o(req), .wake_irq_o(irq), .timeout_o(tmo),
    .wake_id_o(wid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Behavioural reference: event order {act, sup, wake, epu} = bits [3:0]
  typedef enum {M_RUN, M_ENTER, M_SLEEP, M_EXIT} mmode_t;
  logic [63:0] m_pipe[$];
  logic [3:0]  m_prev = '0, m_enb = '0;
  bit          m_live = 0, m_irq = 0, m_to = 0;
  mmode_t      m_mode = M_RUN;
  int          m_cnt = 0, m_id = 0;

  function automatic logic [3:0] got_enb();
    return {evt.activate_low_pwr_enb, evt.event_suppress_enb, evt.wake_now_enb, evt.epu_enable_enb};
  endfunction
  function automatic logic [3:0] got_d();
    return {evt.activate_low_pwr_d, evt.event_suppress_d, evt.wake_now_d, evt.epu_enable_d};
  endfunction

  task automatic model_step();
    logic [63:0] ws, wm;
    logic [3:0]  lvl, det;
    logic [1:0]  cfg [4];
    bit          go;
    if (!rst_n) begin
      m_pipe.delete();
      repeat (SYNC) m_pipe.push_back('0);
      m_prev = '0; m_enb = '0; m_live = 0; m_mode = M_RUN;
      m_cnt = 0; m_irq = 0; m_to = 0; m_id = 0;
    end else begin
      ws  = m_pipe[0];
      wm  = (ws ^ {inv1.invert_q, inv0.invert_q}) & {en1.enable_q, en0.enable_q};
      lvl = {lp, sup, (wm != 0), epu};
      cfg[3] = ctl.activate_low_pwr_edge_q; cfg[2] = ctl.event_suppress_edge_q;
      cfg[1] = ctl.wake_now_edge_q;         cfg[0] = ctl.epu_enable_edge_q;
      for (int s = 0; s < 4; s++)
        det[s] = m_live && ((lvl[s] && !m_prev[s] && cfg[s][0]) ||
                            (!lvl[s] && m_prev[s] && cfg[s][1]));
      m_enb = det; m_prev = lvl; m_live = 1;
      m_irq = 0; m_to = 0;
      go = (wm != 0) && !sup;
      case (m_mode)
        M_RUN:   if (det[3] && epu) begin m_mode = M_ENTER; m_cnt = 0; end
        M_ENTER: begin
          if (go) m_mode = M_RUN;
          else if (ack) m_mode = M_SLEEP;
          else if (m_cnt == TMO) begin m_mode = M_RUN; m_to = 1; end
          else m_cnt++;
        end
        M_SLEEP: if (go) begin
          m_mode = M_EXIT;
          for (int i = 0; i < 64; i++) if (wm[i]) begin m_id = i; break; end
        end
        M_EXIT:  if (!ack) begin m_mode = M_RUN; m_irq = 1; end
        default: m_mode = M_RUN;
      endcase
      void'(m_pipe.pop_front());
      m_pipe.push_back(wake_in);
    end
  endtask

  task automatic tick();
    bit m_req;
    @(posedge clk);
    model_step();
    #1;
    m_req = (m_mode == M_ENTER) || (m_mode == M_SLEEP);
    chk("model_enb", 64'(got_enb()), 64'(m_enb));
    chk("model_d",   64'(got_d()),   64'(m_enb));
    chk("model_fsm", 64'({req, irq, tmo, wid}), 64'({m_req, m_irq, m_to, 6'(m_id)}));
  endtask

  task automatic set_cfg(input logic [1:0] a, input logic [1:0] s, input logic [1:0] w, input logic [1:0] e);
    ctl.activate_low_pwr_edge_q = a; ctl.event_suppress_edge_q = s;
    ctl.wake_now_edge_q = w;         ctl.epu_enable_edge_q = e;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(); tick();
    rst_n = 1'b1; tick();
  endtask

  typedef struct { logic lp, sup, epu, ack; logic [3:0] enb; logic req; } vec_t;
  vec_t tbl [11];

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    bit seen;
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'b1001, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1};

    en0.enable_q = '0; en1.enable_q = '0; inv0.invert_q = '0; inv1.invert_q = '0;
    evt.activate_low_pwr_q = 1'b1; evt.event_suppress_q = 1'b0;
    evt.wake_now_q = 1'b1; evt.epu_enable_q = 1'b0;

    // Reset with lp held high and all edges enabled: no spurious pulse
    set_cfg(2'b11, 2'b11, 2'b11, 2'b11);
    lp = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", 64'({got_enb(), got_d(), req, irq, tmo, wid}), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_reset_quiet", 64'({got_enb(), got_d(), req, irq, tmo, wid}), 64'd0);
    end

    // Vector table: act rise-only, sup fall-only, wake off, epu both
    lp = 1'b0;
    do_reset();
    set_cfg(2'b01, 2'b10, 2'b00, 2'b11);
    repeat (2) tick();
    foreach (tbl[i]) begin
      lp = tbl[i].lp; sup = tbl[i].sup; epu = tbl[i].epu; ack = tbl[i].ack;
      tick();
      chk($sformatf("tbl%0d_enb", i), 64'(got_enb()), 64'(tbl[i].enb));
      chk($sformatf("tbl%0d_d", i),   64'(got_d()),   64'(tbl[i].enb));
      chk($sformatf("tbl%0d_req", i), 64'(req),       64'(tbl[i].req));
    end

    // Inverted wake bit 0: pulse three cycles after the input drops
    lp = 1'b0; sup = 1'b0; epu = 1'b0; ack = 1'b0;
    do_reset();
    set_cfg(2'b00, 2'b00, 2'b01, 2'b00);
    en0.enable_q = 32'h1; inv0.invert_q = 32'h1; wake_in[0] = 1'b1;
    repeat (4) tick();
    wake_in[0] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("inv_wake_c%0d", i), 64'(evt.wake_now_enb), (i == 3) ? 64'd1 : 64'd0);
    end
    en0.enable_q = '0;
    for (int i = 0; i < 6; i++) begin
      wake_in[0] = (i == 2);
      tick();
      chk("disabled_no_wake", 64'(evt.wake_now_enb), 64'd0);
    end
    inv0.invert_q = '0;

    // Full sleep cycle through wake bit 37
    set_cfg(2'b01, 2'b00, 2'b00, 2'b00);
    en1.enable_q = 32'h20; wake_in = '0; epu = 1'b1; lp = 1'b0;
    repeat (3) tick();
    lp = 1'b1; tick();
    chk("enter_req", 64'(req), 64'd1);
    repeat (4) tick();
    ack = 1'b1; tick();
    chk("sleep_req", 64'(req), 64'd1);
    wake_in[37] = 1'b1;
    n = 0; seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin tick(); n++; seen = !req; end
    chk("exit_latency", 64'(n), 64'd3);
    chk("exit_wake_id", 64'(wid), 64'd37);
    chk("exit_no_irq_yet", 64'(irq), 64'd0);
    ack = 1'b0; tick();
    chk("irq_pulse", 64'({irq, req}), 64'b10);
    tick();
    chk("irq_one_cycle", 64'(irq), 64'd0);

    // Suppress holds SLEEP; releasing it exits on the next cycle
    wake_in[37] = 1'b0; lp = 1'b0;
    repeat (3) tick();
    lp = 1'b1; tick();
    ack = 1'b1; tick();
    sup = 1'b1; wake_in[37] = 1'b1;
    repeat (5) tick();
    chk("suppressed_sleep", 64'(req), 64'd1);
    sup = 1'b0; tick();
    chk("unsuppress_exit", 64'({req, wid}), 64'({1'b0, 6'd37}));
    ack = 1'b0; tick();

    // Ack timeout: cnt runs 0..ACK_TIMEOUT in ENTER, so 256 request cycles
    wake_in[37] = 1'b0; lp = 1'b0;
    repeat (3) tick();
    lp = 1'b1; tick();
    n = 1; seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if (req) n++; else seen = 1;
    end
    chk("timeout_reached", 64'(seen), 64'd1);
    chk("timeout_enter_cycles", 64'(n), 64'(TMO + 1));
    chk("timeout_pulse", 64'(tmo), 64'd1);
    tick();
    chk("timeout_one_cycle", 64'(tmo), 64'd0);

    // Abort beats a simultaneous ack
    lp = 1'b0; tick();
    lp = 1'b1; tick(); tick();
    inv1.invert_q = 32'h20; ack = 1'b1; tick();
    chk("abort_req", 64'({req, tmo}), 64'd0);
    tick();
    chk("abort_stays_run", 64'(req), 64'd0);
    inv1.invert_q = '0; ack = 1'b0;
    repeat (2) tick();

    // Reset during ENTER drops the request on the next cycle
    lp = 1'b0; tick();
    lp = 1'b1; tick();
    chk("enter_before_reset", 64'(req), 64'd1);
    rst_n = 1'b0; tick();
    chk("reset_mid_enter", 64'(req), 64'd0);
    rst_n = 1'b1; tick();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0)
        set_cfg(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
      if ($urandom_range(0, 99) == 0) begin
        en0.enable_q  = 32'h1 << $urandom_range(0, 31);
        en1.enable_q  = 32'h1 << $urandom_range(0, 31);
        inv0.invert_q = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
        inv1.invert_q = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
      end
      if ($urandom_range(0, 3) == 0)
        wake_in = {$urandom & $urandom & $urandom, $urandom & $urandom & $urandom};
      if ($urandom_range(0, 5) == 0)  lp  = ~lp;
      if ($urandom_range(0, 9) == 0)  sup = ~sup;
      if ($urandom_range(0, 19) == 0) epu = ~epu;
      if ($urandom_range(0, 3) == 0)  ack = ~ack;
      rst_n = ($urandom_range(0, 499) != 0);
      evt.activate_low_pwr_q = 1'($urandom); evt.event_suppress_q = 1'($urandom);
      evt.wake_now_q = 1'($urandom);         evt.epu_enable_q = 1'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
